wb_timer: RTL and testbench
===========================

# wb_timer

Wishbone B4 classic-cycle responder that gives the picorv32 Wishbone SoC a 64-bit free-running timer with a prescaler, a 64-bit compare register and a level interrupt. It connects to the shared Wishbone intercon as a slave beside sram0, rom0 and uart0. Software on the CPU reads the time and programs compare events through the register map in Operation.

## Interface
Parameters:
- `PRESCALE_WIDTH`, default 16: width of the prescale divisor register.
- `RESET_PRESCALE`, default 0: divisor value after reset. 0 means one tick per clock.

Ports:
- `wb_clk_i`  in  1  system clock.
- `wb_rst_n_i`  in  1  reset, synchronous, active-low.
- `wb_adr_i`  in  3  word address (bus address bits [4:2]).
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte-lane enables for writes.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_dat_o`  out  32  read data.
- `wb_ack_o`  out  1  acknowledge.
- `wb_err_o`  out  1  error. Tied to 0.
- `irq_o`  out  1  level interrupt.

## Operation
Register map (word offset):
- 0 CTRL: [0] EN (counting), [1] IE (interrupt enable), [2] AR (auto-reload). Bits [31:3] read 0.
- 1 PRESCALE: [PRESCALE_WIDTH-1:0] divisor minus 1.
- 2 COUNT_LO, 3 COUNT_HI: 64-bit counter, readable and writable.
- 4 CMP_LO, 5 CMP_HI: 64-bit compare. Reset value is all ones.
- 6 STATUS: [0] MATCH, sticky. Writing 1 clears it (W1C).
- 7: reads 0, writes are ignored, still acked.

Bus access:
- Writes honour `wb_sel_i` per byte.
- Unused register bits read as 0.

Prescaler:
- `pcnt` counts 0..PRESCALE while EN=1. At PRESCALE it wraps to 0 and emits a one-cycle `tick`.
- EN=0 holds both `pcnt` and the counter.
- Writing PRESCALE resets `pcnt` to 0.

Counter, on `tick`:
- If AR=1 and count==cmp: count becomes 0 and MATCH is set.
- Otherwise count becomes count+1, wrapping 2^64-1 to 0.

Compare:
- If AR=0, MATCH is set on any cycle where count >= cmp (unsigned 64-bit), even while EN=0.
- `irq_o` = MATCH & IE.

Simultaneous events:
- A bus write to COUNT_LO/HI in the same cycle as `tick` takes priority over the increment (the written bytes win; unwritten bytes keep their old value, no increment).
- A MATCH set and a W1C clear in the same cycle: set wins.
- A write to CTRL, CMP or PRESCALE takes effect from the next cycle.

Reset values:
- All outputs are 0.
- CTRL=0, PRESCALE=RESET_PRESCALE, count=0, cmp=all ones, MATCH=0.

## Timing
Handshake:
- `wb_ack_o` is registered. It asserts the cycle after `wb_cyc_i & wb_stb_i & ~wb_ack_o` and stays high for exactly one cycle. Latency is 1 wait state.
- Back-to-back strobes are acked every other cycle.
- `wb_dat_o` is valid while `wb_ack_o`=1 and is 0 otherwise.
- A write commits on the same edge that raises ack.
- If `wb_stb_i` drops before the ack, no further ack is produced. A write already committed stays committed.

Counter and interrupt:
- `tick` to count update takes one cycle.
- Compare to MATCH takes one cycle. MATCH to `irq_o` is combinational.

Reset:
- Reset asserted mid-access drops `wb_ack_o` on the next edge. No write commits in that cycle.

## Configuration
Macro `WB_TIMER_SNAPSHOT_EN`.
- **Defined:** a COUNT_LO read also captures count[63:32] into a shadow register. COUNT_HI reads return the shadow, which gives a tear-free 64-bit read as LO then HI.
- **Undefined:** COUNT_HI returns the live upper word and no shadow flop exists.

## Structure
- Package `wb_timer_pkg` holds:
  - the register offset localparams (CTRL..STATUS);
  - the CTRL bit indices;
  - the CMP reset constant.
- Sub-module `wb_timer_prescaler` takes EN, divisor and restart, and outputs `tick`.
- Register file, counter and compare stay in `wb_timer`.

## Test plan
1. **Reset:** after reset, read all offsets → CTRL 0, PRESCALE 0, COUNT 0, CMP 0xFFFFFFFF/0xFFFFFFFF, STATUS 0. `irq_o`=0. Each ack arrives 1 cycle after strobe.
2. **Prescaler:** PRESCALE=3, CTRL=1, wait 40 cycles → COUNT_LO = 10 ±1. With PRESCALE=0 the count advances by 1 per clock.
3. **Interrupt:** CMP=0x20, CTRL=3 → MATCH is set and `irq_o` rises when count reaches 0x20. W1C STATUS=1 while count >= cmp → MATCH stays 1. Set CMP=0x100, then W1C → `irq_o`=0.
4. **Auto-reload:** CMP=5, CTRL=7, PRESCALE=0 → count sequence 0..5,0..5 with MATCH set on each wrap. A W1C landing on a reload cycle leaves MATCH=1.
5. **64-bit carry:** write COUNT = 0x00000000_FFFFFFFE, EN=1 → read LO=0x00000001 then HI=0x00000001. With the snapshot macro defined, a carry between the LO and HI reads does not change the HI value returned.
6. **Bus edge cases:**
   - byte write `wb_sel_i`=0010 of 0xAB00 to CMP_LO → only byte 1 changes;
   - write COUNT during a tick → the written value wins;
   - reset mid-write → no commit and no ack.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared register offsets, CTRL bit positions, reset constants and the
// byte-lane merge helper for the wb_timer Wishbone slave.
package wb_timer_pkg;

   localparam logic [2:0] ADR_CTRL     = 3'd0;
   localparam logic [2:0] ADR_PRESCALE = 3'd1;
   localparam logic [2:0] ADR_COUNT_LO = 3'd2;
   localparam logic [2:0] ADR_COUNT_HI = 3'd3;
   localparam logic [2:0] ADR_CMP_LO   = 3'd4;
   localparam logic [2:0] ADR_CMP_HI   = 3'd5;
   localparam logic [2:0] ADR_STATUS   = 3'd6;

   localparam int CTRL_EN = 0;
   localparam int CTRL_IE = 1;
   localparam int CTRL_AR = 2;

   localparam logic [63:0] CMP_RESET = '1;

   // Replace only the bytes whose lane enable is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] i_old,
                                              input logic [31:0] i_new,
                                              input logic [3:0]  i_sel);
      logic [31:0] w_res;
      w_res = i_old;
      for (int b = 0; b < 4; b++) begin
         if (i_sel[b]) w_res[b*8 +: 8] = i_new[b*8 +: 8];
      end
      return w_res;
   endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Clock divider for the timer: counts 0..i_div while enabled and emits a
// one-cycle tick on the wrap. i_restart forces the phase back to zero.
module wb_timer_prescaler #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_div,
   input  logic             i_restart,
   output logic             o_tick
);

   logic [WIDTH-1:0] r_pcnt;

   assign o_tick = i_en & (r_pcnt == i_div);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pcnt <= '0;
      end else if (i_restart || o_tick) begin
         r_pcnt <= '0;
      end else if (i_en) begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_timer.sv
// Wishbone B4 classic timer: 64-bit prescaled counter, 64-bit compare, sticky
// MATCH and level irq. Define WB_TIMER_SNAPSHOT_EN for tear-free LO-then-HI reads.
module wb_timer
   import wb_timer_pkg::*;
#(
   parameter int                      PRESCALE_WIDTH = 16,
   parameter logic [PRESCALE_WIDTH-1:0] RESET_PRESCALE = '0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic [2:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        irq_o
);

   logic                      r_ack;
   logic [31:0]               r_dat;
   logic [2:0]                r_ctrl;
   logic [PRESCALE_WIDTH-1:0] r_presc;
   logic [63:0]               r_count;
   logic [63:0]               r_cmp;
   logic                      r_match;

   logic                      w_req, w_wr, w_rd, w_tick;
   logic                      w_reload, w_set, w_clr;
   logic [63:0]               w_count_nxt;
   logic [PRESCALE_WIDTH-1:0] w_presc_nxt;
   logic [31:0]               w_rdata, w_count_hi_rd;

   // A new request is accepted only while ack is low, giving one wait state.
   assign w_req = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_wr  = w_req & wb_we_i;
   assign w_rd  = w_req & ~wb_we_i;

   wb_timer_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
      .i_clk     (wb_clk_i),
      .i_rst_n   (wb_rst_n_i),
      .i_en      (r_ctrl[CTRL_EN]),
      .i_div     (r_presc),
      .i_restart (w_wr && (wb_adr_i == ADR_PRESCALE)),
      .o_tick    (w_tick)
   );

   assign w_reload = w_tick & r_ctrl[CTRL_AR] & (r_count == r_cmp);
   assign w_set    = w_reload | (~r_ctrl[CTRL_AR] & (r_count >= r_cmp));
   assign w_clr    = w_wr & (wb_adr_i == ADR_STATUS) & wb_sel_i[0] & wb_dat_i[0];

   // Bus writes to the counter override the tick in the same cycle.
   always_comb begin
      w_count_nxt = r_count;
      if (w_tick) w_count_nxt = w_reload ? 64'd0 : r_count + 64'd1;
      if (w_wr && (wb_adr_i == ADR_COUNT_LO))
         w_count_nxt = {r_count[63:32], byte_merge(r_count[31:0], wb_dat_i, wb_sel_i)};
      if (w_wr && (wb_adr_i == ADR_COUNT_HI))
         w_count_nxt = {byte_merge(r_count[63:32], wb_dat_i, wb_sel_i), r_count[31:0]};
   end

   always_comb begin
      w_presc_nxt = r_presc;
      for (int i = 0; i < PRESCALE_WIDTH; i++) begin
         w_presc_nxt[i] = wb_sel_i[i/8] ? wb_dat_i[i] : r_presc[i];
      end
   end

`ifdef WB_TIMER_SNAPSHOT_EN
   logic [31:0] r_shadow;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         r_shadow <= '0;
      end else if (w_rd && (wb_adr_i == ADR_COUNT_LO)) begin
         r_shadow <= r_count[63:32];
      end
   end

   assign w_count_hi_rd = r_shadow;
`else
   assign w_count_hi_rd = r_count[63:32];
`endif

   always_comb begin
      w_rdata = '0;
      case (wb_adr_i)
         ADR_CTRL:     w_rdata = {29'd0, r_ctrl};
         ADR_PRESCALE: w_rdata = 32'(r_presc);
         ADR_COUNT_LO: w_rdata = r_count[31:0];
         ADR_COUNT_HI: w_rdata = w_count_hi_rd;
         ADR_CMP_LO:   w_rdata = r_cmp[31:0];
         ADR_CMP_HI:   w_rdata = r_cmp[63:32];
         ADR_STATUS:   w_rdata = {31'd0, r_match};
         default:      w_rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         r_ack   <= 1'b0;
         r_dat   <= '0;
         r_ctrl  <= '0;
         r_presc <= RESET_PRESCALE;
         r_count <= '0;
         r_cmp   <= CMP_RESET;
         r_match <= 1'b0;
      end else begin
         r_ack   <= w_req;
         r_dat   <= w_rd ? w_rdata : 32'd0;
         r_count <= w_count_nxt;
         r_match <= w_set | (r_match & ~w_clr);
         if (w_wr && (wb_adr_i == ADR_CTRL) && wb_sel_i[0]) r_ctrl <= wb_dat_i[2:0];
         if (w_wr && (wb_adr_i == ADR_PRESCALE)) r_presc <= w_presc_nxt;
         if (w_wr && (wb_adr_i == ADR_CMP_LO))
            r_cmp[31:0] <= byte_merge(r_cmp[31:0], wb_dat_i, wb_sel_i);
         if (w_wr && (wb_adr_i == ADR_CMP_HI))
            r_cmp[63:32] <= byte_merge(r_cmp[63:32], wb_dat_i, wb_sel_i);
      end
   end

   assign wb_dat_o = r_dat;
   assign wb_ack_o = r_ack;
   assign wb_err_o = 1'b0;
   assign irq_o    = r_match & r_ctrl[CTRL_IE];

endmodule

// File: tb/tb_wb_timer.sv
// Randomized bench for wb_timer. Expected counter, MATCH and irq values come from
// closed-form arithmetic on edge numbers (ticks = elapsed / (prescale+1)).
module tb_wb_timer;
   import wb_timer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic        we, cyc, stb;
   logic [31:0] dat_r;
   logic        ack, err, irq;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   int unsigned cyc_n   = 0;

   // Reference model state: counting origin, last rebase point and value.
   bit          m_en = 1'b0;
   int unsigned m_p  = 0;
   int unsigned m_ec = 0;
   int unsigned m_eb = 0;
   logic [63:0] m_base = '0;
   int unsigned m_c  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   wb_timer dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wb_adr_i   (adr),
      .wb_dat_i   (dat_w),
      .wb_sel_i   (sel),
      .wb_we_i    (we),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_dat_o   (dat_r),
      .wb_ack_o   (ack),
      .wb_err_o   (err),
      .irq_o      (irq)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h (edge %0d)", tag, got, exp, cyc_n);
      end
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   // Number of ticks whose count update has landed by edge x.
   function automatic logic [63:0] ticks(input int unsigned x);
      if (!m_en || x < m_ec) return 64'd0;
      return 64'((x - m_ec) / (m_p + 1));
   endfunction

   function automatic logic [63:0] cnt_after(input int unsigned x);
      return m_base + ticks(x) - ticks(m_eb);
   endfunction

   function automatic bit reload_at(input int unsigned z);
      if (z <= m_ec) return 1'b0;
      return (ticks(z) != ticks(z - 1)) && ((ticks(z) % 64'(m_c + 1)) == 64'd0);
   endfunction

   function automatic bit match_from(input int unsigned x, input int unsigned from);
      bit hit;
      hit = 1'b0;
      for (int unsigned z = from; z <= x; z++) if (reload_at(z)) hit = 1'b1;
      return hit;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called 1 time unit after an edge with the bus idle; returns the commit edge.
   task automatic bus_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output int unsigned e_commit);
      int n;
      check("dat_idle", dat_r, 32'd0);
      adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ack && n < 4);
      check("ack_latency", n, 1);
      rd = dat_r;
      e_commit = cyc_n;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      idle(1);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                     output int unsigned e);
      logic [31:0] unused_rd;
      bus_xfer(1'b1, a, d, s, unused_rd, e);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d, output int unsigned e);
      bus_xfer(1'b0, a, 32'd0, 4'h0, d, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] v, v0, s_v;
      logic [63:0] base, cmp, old_c, exp_c;
      logic [31:0] exp_rst[8];
      logic [2:0]  a;
      logic [3:0]  s;
      int unsigned e, e_c, e_lo, e_hi, from, p, c, guard;
      bit          ie;

      rst_n = 1'b0; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Reset state of every offset
      exp_rst = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      check("irq_rst", irq, 1'b0);
      check("err_rst", err, 1'b0);
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), v, e);
         check($sformatf("rst_off%0d", i), v, exp_rst[i]);
      end

      // Free-running compare with AR=0
      for (int t = 0; t < 6; t++) begin
         p    = $urandom_range(0, 4);
         ie   = 1'($urandom_range(0, 1));
         base = {32'($urandom_range(0, 32'h7FFF_FFFF)),
                 (t % 2 == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 40)) : 32'($urandom)};
         cmp  = base + 64'($urandom_range(0, 30));
         wr(ADR_CTRL, 32'd0, 4'hF, e);
         m_en = 1'b0;
         wr(ADR_PRESCALE, p, 4'hF, e);
         wr(ADR_COUNT_LO, base[31:0], 4'hF, e);
         wr(ADR_COUNT_HI, base[63:32], 4'hF, e);
         wr(ADR_CMP_LO, cmp[31:0], 4'hF, e);
         wr(ADR_CMP_HI, cmp[63:32], 4'hF, e);
         wr(ADR_STATUS, 32'd1, 4'hF, e);
         wr(ADR_CTRL, {30'd0, ie, 1'b1}, 4'hF, e_c);
         m_en = 1'b1; m_p = p; m_ec = e_c; m_eb = e_c; m_base = base;
         idle($urandom_range(0, 30));
         rd(ADR_STATUS, v, e);
         check("status_ge", v, {31'd0, cnt_after(e - 2) >= cmp});
         check("irq_ge", irq, ie & (cnt_after(e) >= cmp));
         rd(ADR_COUNT_LO, v, e_lo);
         check("count_lo", v, cnt_after(e_lo - 1) & 64'hFFFF_FFFF);
         rd(ADR_COUNT_HI, v, e_hi);
`ifdef WB_TIMER_SNAPSHOT_EN
         exp_c = cnt_after(e_lo - 1);
`else
         exp_c = cnt_after(e_hi - 1);
`endif
         check("count_hi", v, exp_c >> 32);
         wr(ADR_STATUS, 32'd1, 4'hF, e);
         rd(ADR_STATUS, v, e);
         check("status_after_w1c", v, {31'd0, cnt_after(e - 2) >= cmp});
      end

      // Counter writes colliding with ticks (prescale 0 ticks every cycle)
      wr(ADR_CTRL, 32'd0, 4'hF, e);
      m_en = 1'b0;
      wr(ADR_CMP_LO, 32'hFFFF_FFFF, 4'hF, e);
      wr(ADR_CMP_HI, 32'hFFFF_FFFF, 4'hF, e);
      wr(ADR_PRESCALE, 32'd0, 4'hF, e);
      base = {32'($urandom_range(0, 32'h7FFF_FFFF)), 32'($urandom)};
      wr(ADR_COUNT_LO, base[31:0], 4'hF, e);
      wr(ADR_COUNT_HI, base[63:32], 4'hF, e);
      wr(ADR_CTRL, 32'd1, 4'hF, e_c);
      m_en = 1'b1; m_p = 0; m_ec = e_c; m_eb = e_c; m_base = base;
      for (int k = 0; k < 4; k++) begin
         idle($urandom_range(0, 5));
         a   = (k % 2 == 1) ? ADR_COUNT_HI : ADR_COUNT_LO;
         s_v = $urandom;
         s   = 4'($urandom_range(1, 15));
         wr(a, s_v, s, e);
         old_c = cnt_after(e - 1);
         if (a == ADR_COUNT_LO) m_base = {old_c[63:32], bmerge(old_c[31:0], s_v, s)};
         else                   m_base = {bmerge(old_c[63:32], s_v, s), old_c[31:0]};
         m_eb = e;
         rd(ADR_COUNT_LO, v, e_lo);
         check("tick_wr_lo", v, cnt_after(e_lo - 1) & 64'hFFFF_FFFF);
         rd(ADR_COUNT_HI, v, e_hi);
`ifdef WB_TIMER_SNAPSHOT_EN
         exp_c = cnt_after(e_lo - 1);
`else
         exp_c = cnt_after(e_hi - 1);
`endif
         check("tick_wr_hi", v, exp_c >> 32);
      end

      // Auto-reload
      for (int t = 0; t < 3; t++) begin
         p = (t == 0) ? 0 : $urandom_range(0, 2);
         c = $urandom_range(2, 6);
         wr(ADR_CTRL, 32'd0, 4'hF, e);
         m_en = 1'b0;
         wr(ADR_PRESCALE, p, 4'hF, e);
         wr(ADR_COUNT_LO, 32'd0, 4'hF, e);
         wr(ADR_COUNT_HI, 32'd0, 4'hF, e);
         wr(ADR_CMP_HI, 32'd0, 4'hF, e);
         wr(ADR_CMP_LO, c, 4'hF, e);
         wr(ADR_STATUS, 32'd1, 4'hF, e);
         wr(ADR_CTRL, 32'd7, 4'hF, e_c);
         m_en = 1'b1; m_p = p; m_ec = e_c; m_eb = e_c; m_base = '0; m_c = c;
         from = e_c + 1;
         for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
               guard = 0;
               while (((cyc_n + 1 - m_ec) % ((p + 1) * (c + 1))) != 0 && guard < 40) begin
                  idle(1);
                  guard++;
               end
               wr(ADR_STATUS, 32'd1, 4'hF, e);
               from = e;
            end else begin
               idle($urandom_range(0, 8));
               if (k % 2 == 1) begin
                  wr(ADR_STATUS, 32'd1, 4'hF, e);
                  from = e;
               end
            end
            rd(ADR_COUNT_LO, v, e);
            check("ar_count", v, ticks(e - 1) % 64'(c + 1));
            rd(ADR_STATUS, v, e);
            check("ar_match", v, {31'd0, match_from(e - 1, from)});
            check("ar_irq", irq, match_from(e + 1, from));
         end
      end

      // Byte lanes, unused bits, offset 7 and back-to-back strobes
      wr(ADR_CTRL, 32'd0, 4'hF, e);
      v0 = $urandom;
      wr(ADR_CMP_LO, v0, 4'hF, e);
      wr(ADR_CMP_LO, 32'h0000_AB00, 4'b0010, e);
      rd(ADR_CMP_LO, v, e);
      check("cmp_byte1", v, bmerge(v0, 32'h0000_AB00, 4'b0010));
      for (int k = 0; k < 3; k++) begin
         v0 = $urandom; s_v = $urandom; s = 4'($urandom_range(0, 15));
         wr(ADR_CMP_HI, v0, 4'hF, e);
         wr(ADR_CMP_HI, s_v, s, e);
         rd(ADR_CMP_HI, v, e);
         check("cmp_hi_sel", v, bmerge(v0, s_v, s));
         wr(ADR_PRESCALE, v0, 4'hF, e);
         wr(ADR_PRESCALE, s_v, s, e);
         rd(ADR_PRESCALE, v, e);
         check("presc_sel", v, bmerge(v0, s_v, s) & 32'h0000_FFFF);
      end
      wr(ADR_CTRL, 32'd5, 4'b1110, e);
      rd(ADR_CTRL, v, e);
      check("ctrl_sel_off", v, 32'd0);
      wr(ADR_CTRL, 32'hFFFF_FFFE, 4'b0001, e);
      rd(ADR_CTRL, v, e);
      check("ctrl_unused", v, 32'd6);
      wr(3'd7, 32'hFFFF_FFFF, 4'hF, e);
      rd(3'd7, v, e);
      check("off7", v, 32'd0);

      adr = 3'd7; dat_w = 32'd0; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("b2b_ack%0d", k), ack, (k % 2 == 0) ? 1'b1 : 1'b0);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      idle(1);

      // Reset arriving with a write in flight
      adr = ADR_CMP_LO; dat_w = 32'h1234_5678; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_ack", ack, 1'b0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      rd(ADR_CMP_LO, v, e);
      check("rst_mid_cmp", v, 32'hFFFF_FFFF);
      rd(ADR_CTRL, v, e);
      check("rst_mid_ctrl", v, 32'd0);
      check("rst_mid_irq", irq, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
